riscv_seq_ctrl: RTL and testbench

RISCV_SEQ_CTRL -- requirements
Module: riscv_seq_ctrl

---
 rtl/riscv_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_riscv_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_ctrl.sv
// Instruction sequencer: fetches from instruction memory, issues one word at a
// time to the datapath and retires it on dp_done; stops on an all-zero word.
module riscv_seq_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_out,
    output logic             instr_valid,
    input  logic             dp_done,
    input  logic             dp_redirect,
    input  logic [WIDTH-1:0] dp_target,
    output logic             halted,
    output logic [31:0]      retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [31:0]      ret_q, ret_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            ret_q    <= ret_d;
        end
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = halted_q;
        ret_d    = ret_q;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
            end
            FETCH: begin
                req_d = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    if (imem_rdata == '0) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        valid_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (dp_done) begin
                    ret_d = ret_q + 32'd1;
                    pc_d  = dp_redirect ? (dp_target & ALIGN_MASK) : (pc_q + PC_STEP);
                    if (run) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign retired     = ret_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Randomised bench for riscv_seq_ctrl: a model-driven stimulus process predicts
// fetch/issue/retire/halt events into queues that a negedge monitor consumes.
module tb_riscv_seq_ctrl;

    localparam int unsigned W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, imem_req, imem_ack, instr_valid, dp_done, dp_redirect, halted;
    logic [31:0] imem_addr, imem_rdata, instr_out, dp_target, retired;

    riscv_seq_ctrl #(.WIDTH(W), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .dp_done(dp_done), .dp_redirect(dp_redirect), .dp_target(dp_target),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned failures = 0;

    typedef struct {
        int unsigned cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          dly;
        int          e;
        bit          redir;
        logic [31:0] target;
        bit          run_done;
        bit          drop_run;
        bit          rst_exec;
    } desc_t;

    exp_t fetch_q[$], issue_q[$], ret_q[$], halt_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Random activity on inputs the controller must ignore in the current phase.
    task automatic noise();
        imem_ack    = 1'($urandom_range(1));
        imem_rdata  = $urandom;
        dp_done     = 1'($urandom_range(1));
        dp_redirect = 1'($urandom_range(1));
        dp_target   = $urandom;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        dp_done = 1'b0; dp_redirect = 1'b0; dp_target = '0;
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_instr", instr_out, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_pending", 32'(fetch_q.size() + issue_q.size() + ret_q.size() + halt_q.size()), 32'h0);
        fetch_q.delete(); issue_q.delete(); ret_q.delete(); halt_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic desc_t make_desc(input int s, input int k);
        desc_t d;
        d.instr = $urandom;
        if (d.instr == 32'h0) d.instr = 32'h13;
        if ($urandom_range(19) == 0) d.instr = 32'h0;
        d.dly      = int'($urandom_range(4));
        d.e        = int'($urandom_range(3));
        d.redir    = ($urandom_range(3) == 0);
        d.target   = $urandom;
        d.run_done = ($urandom_range(3) != 0);
        d.drop_run = 1'b0;
        d.rst_exec = (s >= 2) && ($urandom_range(29) == 0);
        if (s == 0) begin
            case (k)
                0: begin d.instr = 32'h0073_0033; d.dly = 0; d.e = 0; d.redir = 0; d.run_done = 1; end
                1: begin d.instr = 32'h0010_0093; d.dly = 0; d.e = 1; d.redir = 1; d.target = 32'h0000_0103; d.run_done = 1; end
                2: begin d.instr = 32'h0020_0113; d.dly = 1; d.e = 0; d.redir = 1; d.target = 32'hFFFF_FFFE; d.run_done = 1; end
                3: begin d.instr = 32'h0030_0193; d.dly = 0; d.e = 0; d.redir = 0; d.run_done = 1; end
                4: begin d.instr = 32'h0040_0213; d.dly = 5; d.e = 2; d.redir = 0; d.run_done = 0; d.drop_run = 1; end
                default: ;
            endcase
        end
        if (s == 1 && k == 0) d.instr = 32'h0;
        return d;
    endfunction

    // Stimulus and reference model: instruction-level timeline of expected events.
    initial begin : drv
        logic [31:0] m_pc, m_ret;
        desc_t d;
        int    n;
        bit    idle, stop;
        for (int s = 0; s < 7; s++) begin
            n    = (s == 0) ? 25 : ((s == 1) ? 1 : 40);
            idle = 1'b1;
            stop = 1'b0;
            do_reset();
            m_pc  = RPC;
            m_ret = '0;
            for (int k = 0; k < n && !stop; k++) begin
                d = make_desc(s, k);
                if (idle) begin
                    do begin
                        @(negedge clk);
                        noise();
                        run = ($urandom_range(3) != 0);
                    end while (!run);
                    fetch_q.push_back('{cyc + 1, m_pc, 32'h0, 32'h0});
                end
                for (int i = 0; i < d.dly; i++) begin
                    @(negedge clk);
                    noise();
                    imem_ack = 1'b0;
                    run = d.drop_run ? 1'b0 : 1'($urandom_range(1));
                end
                @(negedge clk);
                noise();
                imem_ack   = 1'b1;
                imem_rdata = d.instr;
                if (d.drop_run) run = 1'b0;
                if (d.instr == 32'h0) begin
                    halt_q.push_back('{cyc + 1, m_ret, m_pc, 32'h0});
                    repeat (12) begin
                        @(negedge clk);
                        noise();
                        run = 1'($urandom_range(1));
                    end
                    stop = 1'b1;
                end else begin
                    issue_q.push_back('{cyc + 1, d.instr, m_pc, 32'h0});
                    @(negedge clk);
                    noise();
                    if (d.rst_exec) begin
                        @(negedge clk);
                        noise();
                        dp_done = 1'b0;
                        stop = 1'b1;
                    end else begin
                        for (int i = 0; i < d.e; i++) begin
                            @(negedge clk);
                            noise();
                            dp_done = 1'b0;
                        end
                        @(negedge clk);
                        noise();
                        dp_done     = 1'b1;
                        dp_redirect = d.redir;
                        dp_target   = d.target;
                        run         = d.run_done;
                        m_pc  = d.redir ? (d.target & 32'hFFFF_FFFC) : (m_pc + 32'd4);
                        m_ret = m_ret + 32'd1;
                        ret_q.push_back('{cyc + 1, m_ret, m_pc, d.instr});
                        if (d.run_done) fetch_q.push_back('{cyc + 1, m_pc, 32'h0, 32'h0});
                        idle = !d.run_done;
                    end
                end
            end
            if (!stop) begin
                repeat (3) begin
                    @(negedge clk);
                    noise();
                    imem_ack = 1'b0;
                    dp_done  = 1'b0;
                    run      = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(fetch_q.size() + issue_q.size() + ret_q.size() + halt_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: every observable event must match the head of its expectation queue.
    logic        prev_req = 1'b0, prev_halt = 1'b0;
    logic [31:0] prev_ret = '0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst !== 1'b1) begin
            prev_req  = 1'b0;
            prev_halt = 1'b0;
            prev_ret  = '0;
        end else begin
            if (imem_req === 1'b1 && !prev_req) begin
                chk1("fetch_expected", fetch_q.size() != 0, 1'b1);
                if (fetch_q.size() != 0) begin
                    e = fetch_q.pop_front();
                    chk("fetch_cycle", cyc, e.cyc);
                    chk("fetch_addr", imem_addr, e.a);
                end
            end
            if (instr_valid !== 1'b0) begin
                chk1("issue_expected", issue_q.size() != 0, 1'b1);
                if (issue_q.size() != 0) begin
                    e = issue_q.pop_front();
                    chk("issue_cycle", cyc, e.cyc);
                    chk("issue_instr", instr_out, e.a);
                    chk("issue_addr", imem_addr, e.b);
                    chk1("issue_req_low", imem_req, 1'b0);
                end
            end
            if (retired !== prev_ret) begin
                chk1("retire_expected", ret_q.size() != 0, 1'b1);
                if (ret_q.size() != 0) begin
                    e = ret_q.pop_front();
                    chk("retire_cycle", cyc, e.cyc);
                    chk("retire_count", retired, e.a);
                    chk("retire_next_pc", imem_addr, e.b);
                    chk("retire_instr_held", instr_out, e.c);
                end
            end
            if (halted === 1'b1 && !prev_halt) begin
                chk1("halt_expected", halt_q.size() != 0, 1'b1);
                if (halt_q.size() != 0) begin
                    e = halt_q.pop_front();
                    chk("halt_cycle", cyc, e.cyc);
                    chk("halt_retired", retired, e.a);
                    chk("halt_addr", imem_addr, e.b);
                    chk1("halt_req_low", imem_req, 1'b0);
                end
            end
            if (prev_halt) chk1("halt_held", halted, 1'b1);
            prev_req  = imem_req;
            prev_halt = halted;
            prev_ret  = retired;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
